i2c_mem_slave: RTL
==================

# i2c_mem_slave

I2C target that sits on the same `sda`/`scl` bus as the I2C master and acts as the memory end of the I2C memory subsystem. It holds a 128 x 8 register array. It decodes each START + 7-bit address + R/W byte, then either writes the following data bytes into the array or returns array contents to the master. It drives `sda` open-drain only and never stretches `scl`. It reports bus activity and transaction completion to local logic.

## Interface
- `ADDR_W`, 7: memory address width; equals the I2C address field width.
- `DATA_W`, 8: byte width. Fixed at 8.
- `MIN_PHASE`, 8: minimum `scl` high/low phase in `clk` cycles that the block supports.
- `clk`  input  1  system clock, 50 MHz nominal.
- `rst`  input  1  asynchronous, active-low reset.
- `scl`  input  1  I2C clock. Sampled only, never driven.
- `sda`  inout  1  I2C data, open-drain. Driven as `1'b0` when the output enable is set, `1'bz` otherwise.
- `busy`  output  1  High from a detected START until the following STOP.
- `done`  output  1  One-cycle pulse on STOP, only if at least one full byte after the address byte was ACKed or transferred.
- `ackErr`  output  1  Level signal. Set when a STOP or START arrives mid-byte. Cleared at the next START.

## Operation
- **Input conditioning:** `scl` and `sda` each pass through a 2-FF synchronizer followed by a delay register. This yields `sclRise`, `sclFall`, `start` (sda falls while scl is high) and `stop` (sda rises while scl is high). Detection latency is 3 `clk` cycles.
- **Address byte:** MSB first. Bits [7:1] are the memory address. Bit 0 is R/W: 1 = read, 0 = write. Every address is accepted; there is no target-address match.
- **Bit sampling:** on `sclRise`. **Slave drive changes:** on `sclFall`.
- **States:**
  - `IDLE`: on `start` → `ADDR`.
  - `ADDR`: shift 8 bits. After the 8th `sclRise` → `ACK_ADDR`.
  - `ACK_ADDR`: drive `sda` low from the next `sclFall` until the following `sclFall`. Then go to `WR_DATA` if R/W = 0, or `RD_DATA` if R/W = 1.
  - `WR_DATA`: shift 8 bits. On the 8th `sclRise`, write `mem[ptr]` → `ACK_WR`.
  - `ACK_WR`: drive ACK as in `ACK_ADDR`. Then `ptr` ← `ptr`+1 → `WR_DATA`.
  - `RD_DATA`: load `mem[ptr]` into the shift register on entry. On each `sclFall`, present the next bit: drive low for 0, release for 1. After the 8th bit, release `sda` on `sclFall` → `RD_ACK`.
  - `RD_ACK`: sample the master's bit on `sclRise`.
    - ACK (0): `ptr` ← `ptr`+1 → `RD_DATA`.
    - NACK (1): → `WAIT_STOP`, with `sda` released.
  - `WAIT_STOP`: ignore everything except `start` and `stop`.
- **Any state:** `stop` → `IDLE`. `start` → `ADDR`, which is a repeated start. Both release `sda` the same cycle.
- **Pointer:** `ptr` is `ADDR_W` bits and wraps 127 → 0.
- **Partial bytes:** a partial write byte is discarded and never written.
- **Reset:**
  - `sda` output enable = 0 (released).
  - `busy` = 0, `done` = 0, `ackErr` = 0.
  - State = `IDLE`, `ptr` = 0.
  - All memory bytes = 8'h00.
- **Reset mid-transaction:** `sda` is released asynchronously. The block then waits in `IDLE` for a fresh START.

## Timing
- The master's `scl` high and low phases must each be ≥ `MIN_PHASE` clk cycles. The slave changes `sda` 3 cycles after `scl` falls, which is well inside the low phase.
- The write commits 3 cycles after the 8th `scl` rise of a data byte.
- `done` is asserted 4 cycles after the STOP edge on the bus.
- `busy` rises 4 cycles after the START edge and falls in the same cycle `done` pulses.
- Simultaneous `start` and `stop` cannot occur; `stop` takes priority if both are decoded.

## Structure
- **Package `i2c_pkg`:**
  - `state_t` enum: `IDLE`, `ADDR`, `ACK_ADDR`, `WR_DATA`, `ACK_WR`, `RD_DATA`, `RD_ACK`, `WAIT_STOP`.
  - Constants: `I2C_READ` = 1'b1, `I2C_WRITE` = 1'b0, `ACK` = 1'b0, `NACK` = 1'b1.
  - This package is shared with the master.
- **Sub-module `i2c_bus_sync`:** the synchronizers, edge detectors and START/STOP decode. It is reused by the master for `sda` readback.
- **Memory:** a flop array inside `i2c_mem_slave`.

## Test plan
- **Write then read:** master writes 8'h2F to address 7'h55 (`rw`=0, `addr`=7'b1010101, `din`=8'b00101111), then reads 7'h55. Required:
  - Slave ACKs every byte.
  - `dout`=8'h2F.
  - `done` pulses once per transaction.
  - `ackErr`=0.
- **Read after reset:** read address 7'h10 immediately after reset. Required: `dout`=8'h00, and `sda` is released during the master's NACK.
- **Wrap-around:** write 3 bytes A1, B2, C3 starting at 7'h7F. Required:
  - mem[7F]=A1, mem[00]=B2, mem[01]=C3.
  - A sequential read from 7'h7F returns the same three bytes.
- **STOP mid-byte:** issue STOP after 4 data bits of a write to 7'h20. Required:
  - mem[20] stays 00.
  - `ackErr`=1.
  - State returns to `IDLE`.
  - `done` does not pulse.
- **Reset mid-read:** assert `rst`=0 while the slave drives a 0 bit. Required:
  - `sda` reads 1 via the pull-up in the same time step.
  - `busy`=0.
  - A following write to 7'h01 then succeeds.
- **Repeated START:** write address byte for 7'h30, then repeated START and read 7'h30 after a prior write of 8'h5A. Required:
  - Returns 5A.
  - A single `done` at the final STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states and bus-level bit constants.
package i2c_pkg;

    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ACK_ADDR  = 3'd2,
        WR_DATA   = 3'd3,
        ACK_WR    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and decodes scl edges plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise_c,
    output logic o_scl_fall_c,
    output logic o_start_c,
    output logic o_stop_c
);

    // [0],[1] are the synchronizer, [2] is the one-cycle delay for edge detect
    logic [2:0] r_scl;
    logic [2:0] r_sda;
    logic       w_scl_high;

    // Idle bus is high; resetting to 1 avoids spurious edges after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            r_scl <= {r_scl[1:0], i_scl};
            r_sda <= {r_sda[1:0], i_sda};
        end
    end

    assign w_scl_high   = r_scl[1] & r_scl[2];
    assign o_sda        = r_sda[1];
    assign o_scl_rise_c = r_scl[1] & ~r_scl[2];
    assign o_scl_fall_c = ~r_scl[1] & r_scl[2];
    assign o_start_c    = w_scl_high & ~r_sda[1] & r_sda[2];
    assign o_stop_c     = w_scl_high & r_sda[1] & ~r_sda[2];

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C target fronting a 128x8 register array; every address byte is accepted.
module i2c_mem_slave
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MIN_PHASE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    output logic busy,
    output logic done,
    output logic ackErr
);

    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    // Address field is the 7 MSBs of the first byte; sda turnaround must fit the low phase
    if ((DATA_W != 8) || (ADDR_W != DATA_W - 1) || (MIN_PHASE < 4)) begin : g_param_chk
        $error("i2c_mem_slave: unsupported parameter set");
    end

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync u_sync (
        .clk          (clk),
        .rst          (rst),
        .i_scl        (scl),
        .i_sda        (sda),
        .o_sda        (w_sda),
        .o_scl_rise_c (w_scl_rise),
        .o_scl_fall_c (w_scl_fall),
        .o_start_c    (w_start),
        .o_stop_c     (w_stop)
    );

    state_t                 r_state,     w_state;
    logic [DATA_W-1:0]      r_shift,     w_shift;
    logic [BIT_CNT_W-1:0]   r_cnt,       w_cnt;
    logic [ADDR_W-1:0]      r_ptr,       w_ptr;
    logic                   r_rw,        w_rw;
    logic                   r_oe,        w_oe;
    logic                   r_seen,      w_seen;
    logic                   r_err,       w_err;
    logic                   r_stop_done, w_stop_done;
    logic                   r_busy;
    logic                   r_done;

    logic [DATA_W-1:0]      r_mem [MEM_DEPTH];
    logic                   w_we;
    logic [DATA_W-1:0]      w_shift_in;
    logic [ADDR_W-1:0]      w_ptr_inc;
    logic [DATA_W-1:0]      w_rd_cur;
    logic [DATA_W-1:0]      w_rd_next;
    logic                   w_mid_byte;

    assign w_shift_in = {r_shift[DATA_W-2:0], w_sda};
    assign w_ptr_inc  = r_ptr + ADDR_W'(1);
    assign w_rd_cur   = r_mem[r_ptr];
    assign w_rd_next  = r_mem[w_ptr_inc];

    // A START/STOP always follows one scl rise of its own, so only >1 counted bits is a torn byte
    assign w_mid_byte = ((r_state == ADDR) || (r_state == WR_DATA) || (r_state == RD_DATA))
                        && (r_cnt > BIT_CNT_W'(1));

    // Next-state and datapath update
    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_cnt       = r_cnt;
        w_ptr       = r_ptr;
        w_rw        = r_rw;
        w_oe        = r_oe;
        w_seen      = r_seen;
        w_err       = r_err;
        w_stop_done = 1'b0;
        w_we        = 1'b0;

        if (w_stop) begin
            w_state     = IDLE;
            w_oe        = 1'b0;
            w_cnt       = '0;
            w_seen      = 1'b0;
            w_err       = r_err | w_mid_byte;
            w_stop_done = r_seen && (r_state != IDLE);
        end else if (w_start) begin
            w_state = ADDR;
            w_oe    = 1'b0;
            w_cnt   = '0;
            w_seen  = 1'b0;
            w_err   = w_mid_byte;
        end else begin
            case (r_state)
                IDLE: ;
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift = w_shift_in;
                        w_cnt   = r_cnt + BIT_CNT_W'(1);
                        if (r_cnt == BIT_CNT_W'(7)) begin
                            w_ptr   = w_shift_in[DATA_W-1:1];
                            w_rw    = w_sda;
                            w_cnt   = '0;
                            w_state = ACK_ADDR;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (w_scl_fall) begin
                        if (!r_oe) begin
                            w_oe = 1'b1;
                        end else if (r_rw == I2C_READ) begin
                            // This fall also opens the first data bit, so present the MSB now
                            w_shift = {w_rd_cur[DATA_W-2:0], 1'b0};
                            w_oe    = ~w_rd_cur[DATA_W-1];
                            w_cnt   = BIT_CNT_W'(1);
                            w_state = RD_DATA;
                        end else begin
                            w_oe    = 1'b0;
                            w_cnt   = '0;
                            w_state = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift = w_shift_in;
                        w_cnt   = r_cnt + BIT_CNT_W'(1);
                        if (r_cnt == BIT_CNT_W'(7)) begin
                            w_we    = 1'b1;
                            w_seen  = 1'b1;
                            w_cnt   = '0;
                            w_state = ACK_WR;
                        end
                    end
                end
                ACK_WR: begin
                    if (w_scl_fall) begin
                        if (!r_oe) begin
                            w_oe = 1'b1;
                        end else begin
                            w_oe    = 1'b0;
                            w_ptr   = w_ptr_inc;
                            w_state = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == BIT_CNT_W'(8)) begin
                            w_oe    = 1'b0;
                            w_cnt   = '0;
                            w_seen  = 1'b1;
                            w_state = RD_ACK;
                        end else begin
                            w_oe    = ~r_shift[DATA_W-1];
                            w_shift = {r_shift[DATA_W-2:0], 1'b0};
                            w_cnt   = r_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda == ACK) begin
                            w_ptr   = w_ptr_inc;
                            w_shift = w_rd_next;
                            w_cnt   = '0;
                            w_state = RD_DATA;
                        end else begin
                            w_oe    = 1'b0;
                            w_state = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: ;
                default: begin
                    w_state = IDLE;
                    w_oe    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_rw        <= I2C_WRITE;
            r_oe        <= 1'b0;
            r_seen      <= 1'b0;
            r_err       <= 1'b0;
            r_stop_done <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_cnt       <= w_cnt;
            r_ptr       <= w_ptr;
            r_rw        <= w_rw;
            r_oe        <= w_oe;
            r_seen      <= w_seen;
            r_err       <= w_err;
            r_stop_done <= w_stop_done;
            r_busy      <= (r_state != IDLE);
            r_done      <= r_stop_done;
        end
    end

    // Register array; only complete data bytes reach the write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[r_ptr] <= w_shift_in;
        end
    end

    assign sda    = r_oe ? 1'b0 : 1'bz;
    assign busy   = r_busy;
    assign done   = r_done;
    assign ackErr = r_err;

endmodule
